// File: rtl/multi_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// codes, ALU operation codes and datapath mux select codes.
package multi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_LUI = 3'd5;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;

    // True for every opcode the controller can sequence (R-type funct checked separately).
    function automatic logic op_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
            default:                                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/multi_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported functs.
module multi_alu_dec
    import multi_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               funct_legal
);

    always_comb begin
        alu_op      = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADDU: alu_op = ALU_ADD;
            FN_SUBU: alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_JR:   alu_op = ALU_ADD;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// Multicycle MIPS control FSM with memory-stall timeout and sticky fault flags.
// Define MULTI_CTRL_PERF_EN to add the perf_cycles / perf_instret counters.
module multi_ctrl
    import multi_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         ext_op,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem2reg,
    output logic [2:0]         state_o,
    output logic               illegal,
    output logic               timeout_err
`ifdef MULTI_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_instret
`endif
);

    // The fault fires on the not-ready cycle that would bring the count to MEM_TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    logic               illegal_reg, illegal_next;
    logic               timeout_reg, timeout_next;
    logic [ALUOP_W-1:0] rtype_alu_op;
    logic               funct_legal;
    logic               instr_legal;
    logic               mem_wait;
    logic               tmo_hit;

    multi_alu_dec #(
        .ALUOP_W (ALUOP_W)
    ) u_alu_dec (
        .funct       (funct),
        .alu_op      (rtype_alu_op),
        .funct_legal (funct_legal)
    );

    assign instr_legal = op_known(op) && ((op != OP_RTYPE) || funct_legal);
    assign mem_wait    = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
    assign tmo_hit     = (tmo_reg == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            tmo_reg     <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_reg     <= tmo_next;
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        ext_op     = EXT_ZERO;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem2reg    = WD_ALUOUT;

        case (state_reg)
            S_IDLE: state_next = S_FETCH;

            S_FETCH: begin
                mem_read = 1'b1;
                i_or_d   = 1'b0;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_ADD;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_FAULT;
                end
            end

            S_DECODE: begin
                // Branch target is precomputed into ALUOut while the opcode is examined.
                alu_src_b = SRCB_IMMSH;
                ext_op    = EXT_SIGN;
                alu_op    = ALU_ADD;
                if (op == OP_J || op == OP_JAL) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JUMP;
                    state_next = S_FETCH;
                    if (op == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = DST_RA;
                        mem2reg   = WD_PC;
                    end
                end else if (!instr_legal) begin
                    state_next = S_FAULT;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_write   = 1'b1;
                            pc_src     = PC_RS;
                            state_next = S_FETCH;
                        end else begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = SRCB_RT;
                            alu_op     = rtype_alu_op;
                            state_next = S_WB;
                        end
                    end
                    OP_ADDIU, OP_ORI: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRCB_IMM;
                        ext_op     = (op == OP_ADDIU) ? EXT_SIGN : EXT_ZERO;
                        alu_op     = (op == OP_ADDIU) ? ALU_ADD : ALU_OR;
                        state_next = S_WB;
                    end
                    OP_LUI: begin
                        alu_op     = ALU_LUI;
                        ext_op     = EXT_ZERO;
                        state_next = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRCB_IMM;
                        ext_op     = EXT_SIGN;
                        alu_op     = ALU_ADD;
                        state_next = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src_a  = 1'b1;
                        alu_op     = ALU_SUB;
                        pc_src     = PC_BRANCH;
                        pc_write   = (op == OP_BEQ) ? zero : !zero;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_FAULT;
                endcase
            end

            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (op == OP_LW);
                mem_write = (op == OP_SW);
                if (mem_ready) begin
                    state_next = (op == OP_LW) ? S_WB : S_FETCH;
                end else if (tmo_hit) begin
                    state_next = S_FAULT;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op == OP_RTYPE) ? DST_RD : DST_RT;
                mem2reg    = (op == OP_LW) ? WD_MDR : WD_ALUOUT;
                state_next = S_FETCH;
            end

            S_FAULT: state_next = S_FAULT;

            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tmo_next = tmo_reg;
        if (mem_ready || (state_next != state_reg)) begin
            tmo_next = '0;
        end else if (mem_wait) begin
            tmo_next = tmo_reg + 1'b1;
        end
        illegal_next = illegal_reg | ((state_reg == S_DECODE) && (state_next == S_FAULT));
        timeout_next = timeout_reg | (mem_wait && tmo_hit);
    end

    assign state_o     = state_reg;
    assign illegal     = illegal_reg;
    assign timeout_err = timeout_reg;

`ifdef MULTI_CTRL_PERF_EN
    logic [31:0] cycles_reg, instret_reg;
    logic        retire;

    // An instruction retires whenever control returns to FETCH from a later phase.
    assign retire = (state_next == S_FETCH) &&
                    ((state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                     (state_reg == S_MEM) || (state_reg == S_WB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_reg  <= '0;
            instret_reg <= '0;
        end else begin
            if (state_reg != S_IDLE && state_reg != S_FAULT) begin
                cycles_reg <= cycles_reg + 32'd1;
            end
            if (retire) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    assign perf_cycles  = cycles_reg;
    assign perf_instret = instret_reg;
`endif

endmodule

// File: tb/tb_multi_ctrl.sv
// Randomized bench for multi_ctrl: each instruction expands into an expected per-cycle
// trace built from the instruction's phase list, which is then replayed against the DUT.
module tb_multi_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  ext_op;
    logic        reg_write;
    logic [1:0]  reg_dst, mem2reg;
    logic [2:0]  state_o;
    logic        illegal, timeout_err;
`ifdef MULTI_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    int checks   = 0;
    int failures = 0;

    multi_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .ext_op      (ext_op),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem2reg     (mem2reg),
        .state_o     (state_o),
        .illegal     (illegal),
        .timeout_err (timeout_err)
`ifdef MULTI_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_instret(perf_instret)
`endif
    );

    always #5 clk = ~clk;

    logic [22:0] dut_vec;
    assign dut_vec = {state_o, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
                      alu_src_a, alu_src_b, alu_op, ext_op, reg_write, reg_dst, mem2reg};

    // Instruction kinds; the five ALU R-types are ordered so kind == expected alu_op.
    localparam int K_ADDU = 0, K_SUBU = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_JR = 5;
    localparam int K_ADDIU = 6, K_ORI = 7, K_LUI = 8, K_LW = 9, K_SW = 10;
    localparam int K_BEQ = 11, K_BNE = 12, K_J = 13, K_JAL = 14, K_BADOP = 15, K_BADFN = 16;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic        z;
        logic [22:0] vec;
        logic [1:0]  flags;   // {illegal, timeout_err}
    } step_t;

    step_t q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] pk(input int st, mr, mw, iod, irw, pcw, pcs, asa, asb,
                                       aop, ext, rw, rd, m2r);
        logic [22:0] v;
        v = {st[2:0], mr[0], mw[0], iod[0], irw[0], pcw[0], pcs[1:0], asa[0], asb[1:0],
             aop[2:0], ext[1:0], rw[0], rd[1:0], m2r[1:0]};
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] op_of(input int k);
        case (k)
            K_ADDIU: return 6'h09;
            K_ORI:   return 6'h0d;
            K_LUI:   return 6'h0f;
            K_LW:    return 6'h23;
            K_SW:    return 6'h2b;
            K_BEQ:   return 6'h04;
            K_BNE:   return 6'h05;
            K_J:     return 6'h02;
            K_JAL:   return 6'h03;
            K_BADOP: return 6'h3f;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] fn_of(input int k);
        case (k)
            K_ADDU:  return 6'h21;
            K_SUBU:  return 6'h23;
            K_AND:   return 6'h24;
            K_OR:    return 6'h25;
            K_SLT:   return 6'h2a;
            K_JR:    return 6'h08;
            K_BADFN: return 6'h3f;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic add_step(input logic [5:0] o, f, input logic rdy, z,
                            input logic [22:0] v, input logic [1:0] fl);
        step_t s;
        s.op = o; s.fn = f; s.rdy = rdy; s.z = z; s.vec = v; s.flags = fl;
        q.push_back(s);
    endtask

    // Expected trace: FETCH (with fs stalls), DECODE, EXEC, MEM (with ms stalls), WB.
    // A stall count of 15 or more ends in FAULT with timeout_err raised.
    task automatic build_instr(input int k, input int fs, input int ms, input int zf);
        logic [5:0]  o, f;
        logic        z;
        logic [22:0] v;
        o = op_of(k);
        f = fn_of(k);
        for (int i = 0; i < fs && i < 15; i++)
            add_step(o, f, 1'b0, rb(), pk(1,1,0,0,0,0,0,0,0,0,0,0,0,0), 2'b00);
        if (fs >= 15) begin
            for (int i = 0; i < 5; i++) add_step(o, f, rb(), rb(), pk(6,0,0,0,0,0,0,0,0,0,0,0,0,0), 2'b01);
            return;
        end
        add_step(o, f, 1'b1, rb(), pk(1,1,0,0,1,1,0,0,1,0,0,0,0,0), 2'b00);

        if (k == K_J)   begin add_step(o, f, rb(), rb(), pk(2,0,0,0,0,1,2,0,3,0,1,0,0,0), 2'b00); return; end
        if (k == K_JAL) begin add_step(o, f, rb(), rb(), pk(2,0,0,0,0,1,2,0,3,0,1,1,2,2), 2'b00); return; end
        add_step(o, f, rb(), rb(), pk(2,0,0,0,0,0,0,0,3,0,1,0,0,0), 2'b00);
        if (k == K_BADOP || k == K_BADFN) begin
            for (int i = 0; i < 10; i++) add_step(o, f, rb(), rb(), pk(6,0,0,0,0,0,0,0,0,0,0,0,0,0), 2'b10);
            return;
        end

        z = (zf > 1) ? rb() : (zf == 1);
        case (k)
            K_JR:           v = pk(3,0,0,0,0,1,3,0,0,0,0,0,0,0);
            K_ADDIU:        v = pk(3,0,0,0,0,0,0,1,2,0,1,0,0,0);
            K_ORI:          v = pk(3,0,0,0,0,0,0,1,2,3,0,0,0,0);
            K_LUI:          v = pk(3,0,0,0,0,0,0,0,0,5,0,0,0,0);
            K_LW, K_SW:     v = pk(3,0,0,0,0,0,0,1,2,0,1,0,0,0);
            K_BEQ:          v = pk(3,0,0,0,0,z,1,1,0,1,0,0,0,0);
            K_BNE:          v = pk(3,0,0,0,0,!z,1,1,0,1,0,0,0,0);
            default:        v = pk(3,0,0,0,0,0,0,1,0,k,0,0,0,0);
        endcase
        add_step(o, f, rb(), z, v, 2'b00);
        if (k == K_JR || k == K_BEQ || k == K_BNE) return;

        if (k == K_LW || k == K_SW) begin
            v = pk(4, k == K_LW, k == K_SW, 1,0,0,0,0,0,0,0,0,0,0);
            for (int i = 0; i < ms && i < 15; i++) add_step(o, f, 1'b0, rb(), v, 2'b00);
            if (ms >= 15) begin
                for (int i = 0; i < 5; i++) add_step(o, f, rb(), rb(), pk(6,0,0,0,0,0,0,0,0,0,0,0,0,0), 2'b01);
                return;
            end
            add_step(o, f, 1'b1, rb(), v, 2'b00);
            if (k == K_SW) return;
        end
        add_step(o, f, rb(), rb(), pk(5,0,0,0,0,0,0,0,0,0,0,1, k <= K_SLT, k == K_LW), 2'b00);
    endtask

    task automatic play();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            op = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
            #1;
            check_eq($sformatf("out_state%0d", s.vec[22:20]), 32'(dut_vec), 32'(s.vec));
            check_eq("flags", 32'({illegal, timeout_err}), 32'(s.flags));
        end
    endtask

    task automatic run(input int k, input int fs, input int ms, input int zf);
        $display("instr kind=%0d op=%02h fetch_stall=%0d mem_stall=%0d", k, op_of(k), fs, ms);
        build_instr(k, fs, ms, zf);
        play();
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'h00; funct = 6'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("reset_out", 32'(dut_vec), 32'd0);
        check_eq("reset_flags", 32'({illegal, timeout_err}), 32'd0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(state_o), 32'd0);
        check_eq("async_rst_illegal", 32'(illegal), 32'd0);
        check_eq("async_rst_out", 32'(dut_vec), 32'd0);
        do_reset();
    endtask

    function automatic int pick_stall();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 14;
        if (sel < 4)  return $urandom_range(1, 3);
        return 0;
    endfunction

    initial begin
        do_reset();
`ifdef MULTI_CTRL_PERF_EN
        run(K_ADDU, 0, 0, 2);
        @(negedge clk);
        #1;
        check_eq("perf_instret", perf_instret, 32'd1);
        check_eq("perf_cycles", perf_cycles, 32'd4);
        do_reset();
`endif
        run(K_ADDU, 0, 0, 2);
        run(K_LW, 0, 3, 2);
        run(K_BEQ, 0, 0, 1);
        run(K_BNE, 0, 0, 1);
        run(K_JAL, 0, 0, 2);
        run(K_ADDU, 14, 0, 2);
        run(K_SW, 0, 14, 2);

        for (int n = 0; n < 80; n++)
            run($urandom_range(K_ADDU, K_JAL), pick_stall(), pick_stall(), 2);

        do_reset();
        run(K_ADDU, 15, 0, 2);
        do_reset();
        run(K_LW, 0, 15, 2);
        do_reset();
        run(K_BADOP, 0, 0, 2);
        reset_mid_cycle();
        run(K_BADFN, 1, 0, 2);
        reset_mid_cycle();
        run(K_J, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
